// File: rtl/dmem_arbiter_if.sv
// Requester / response / data-memory signal bundle for the two-port data memory arbiter.
// slave is the arbiter side, master is the side driving requests and modelling the memory.
interface dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req0_valid;
  logic          req0_ready;
  logic          req0_we;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata;
  logic          req1_valid;
  logic          req1_ready;
  logic          req1_we;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata;

  logic          rsp0_valid;
  logic          rsp0_ready;
  logic [DW-1:0] rsp0_rdata;
  logic          rsp1_valid;
  logic          rsp1_ready;
  logic [DW-1:0] rsp1_rdata;

  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata,
    input  req1_valid, req1_we, req1_addr, req1_wdata,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata,
    input  rsp0_ready, rsp1_ready,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    output req1_valid, req1_we, req1_addr, req1_wdata,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata,
    output rsp0_ready, rsp1_ready,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port data memory.
// One transaction in flight: IDLE accepts, ACCESS touches memory, RESP holds the response.
module dmem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t        state_reg;
  logic          gnt_reg;
  logic          prio_reg;
  logic          we_reg;
  logic [AW-1:0] addr_reg;
  logic [DW-1:0] wdata_reg;
  logic [DW-1:0] rsp_data_reg;

  logic any_valid;
  logic gnt_next;
  logic accept;
  logic rsp_hs;
  logic in_access;
  logic in_resp;

  // With both requesters valid the pointer decides; otherwise the lone valid one wins.
  assign any_valid = bus.req0_valid | bus.req1_valid;
  assign gnt_next  = (bus.req0_valid & bus.req1_valid) ? prio_reg : bus.req1_valid;
  assign accept    = rst_n & (state_reg == IDLE) & any_valid;

  assign bus.req0_ready = accept & ~gnt_next;
  assign bus.req1_ready = accept &  gnt_next;

  assign in_access = (state_reg == ACCESS);
  assign in_resp   = (state_reg == RESP);
  assign rsp_hs    = in_resp & (gnt_reg ? bus.rsp1_ready : bus.rsp0_ready);

  assign bus.mem_read  = in_access & ~we_reg;
  assign bus.mem_write = in_access &  we_reg;
  assign bus.mem_addr  = in_access ? addr_reg  : '0;
  assign bus.mem_wdata = in_access ? wdata_reg : '0;

  assign bus.rsp0_valid = in_resp & ~gnt_reg;
  assign bus.rsp1_valid = in_resp &  gnt_reg;
  assign bus.rsp0_rdata = (in_resp & ~gnt_reg) ? rsp_data_reg : '0;
  assign bus.rsp1_rdata = (in_resp &  gnt_reg) ? rsp_data_reg : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      gnt_reg      <= 1'b0;
      prio_reg     <= 1'b0;
      we_reg       <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      rsp_data_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (any_valid) begin
            gnt_reg   <= gnt_next;
            we_reg    <= gnt_next ? bus.req1_we    : bus.req0_we;
            addr_reg  <= gnt_next ? bus.req1_addr  : bus.req0_addr;
            wdata_reg <= gnt_next ? bus.req1_wdata : bus.req0_wdata;
            state_reg <= ACCESS;
          end
        end
        ACCESS: begin
          // Write responses carry zero so a requester never sees stale read data.
          rsp_data_reg <= we_reg ? '0 : bus.mem_rdata;
          state_reg    <= RESP;
        end
        RESP: begin
          if (rsp_hs) begin
            prio_reg  <= ~gnt_reg;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: reset, contention, vector table, backpressure, mid-access reset.
module tb_dmem_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  dmem_arbiter_if #(.AW(32), .DW(32)) bus ();

  dmem_arbiter #(.AW(32), .DW(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural data memory: combinational read, write on the rising edge.
  logic [31:0] tb_mem [0:255];
  assign bus.mem_rdata = tb_mem[bus.mem_addr[9:2]];
  always @(posedge clk) begin
    if (bus.mem_write) tb_mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
  end

  typedef struct {
    int          req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    int          dly;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check("mem_rw_exclusive", 32'(bus.mem_read & bus.mem_write), 32'd0);
      check("one_req_ready", 32'(bus.req0_ready & bus.req1_ready), 32'd0);
      check("one_rsp_valid", 32'(bus.rsp0_valid & bus.rsp1_valid), 32'd0);
    end
  end

  task automatic drive_req(input int n, input logic v, input logic we,
                           input logic [31:0] a, input logic [31:0] d);
    if (n == 0) begin
      bus.req0_valid = v; bus.req0_we = we; bus.req0_addr = a; bus.req0_wdata = d;
    end else begin
      bus.req1_valid = v; bus.req1_we = we; bus.req1_addr = a; bus.req1_wdata = d;
    end
  endtask

  task automatic set_rsp_ready(input int n, input logic r);
    if (n == 0) bus.rsp0_ready = r;
    else        bus.rsp1_ready = r;
  endtask

  function automatic logic get_ready(input int n);
    return (n == 0) ? bus.req0_ready : bus.req1_ready;
  endfunction

  function automatic logic get_rsp_valid(input int n);
    return (n == 0) ? bus.rsp0_valid : bus.rsp1_valid;
  endfunction

  function automatic logic [31:0] get_rsp_rdata(input int n);
    return (n == 0) ? bus.rsp0_rdata : bus.rsp1_rdata;
  endfunction

  task automatic run_vec(input vec_t v);
    int waited;
    waited = 0;
    set_rsp_ready(v.req, v.dly == 0);
    @(posedge clk); #1;
    drive_req(v.req, 1'b1, v.we, v.addr, v.wdata);
    @(negedge clk);
    while (!get_ready(v.req) && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("accept", 32'(get_ready(v.req)), 32'd1);
    check("other_ready", 32'(get_ready(1 - v.req)), 32'd0);
    @(posedge clk); #1;
    drive_req(v.req, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    check("mem_read", 32'(bus.mem_read), 32'(!v.we));
    check("mem_write", 32'(bus.mem_write), 32'(v.we));
    check("mem_addr", bus.mem_addr, v.addr);
    check("mem_wdata", bus.mem_wdata, v.wdata);
    check("rsp_early", 32'(get_rsp_valid(v.req)), 32'd0);
    @(negedge clk);
    check("rsp_valid", 32'(get_rsp_valid(v.req)), 32'd1);
    check("rsp_rdata", get_rsp_rdata(v.req), v.exp);
    check("rsp_other_valid", 32'(get_rsp_valid(1 - v.req)), 32'd0);
    check("rsp_other_rdata", get_rsp_rdata(1 - v.req), 32'd0);
    check("mem_idle_rd", 32'(bus.mem_read | bus.mem_write), 32'd0);
    check("mem_idle_addr", bus.mem_addr, 32'd0);
    for (int i = 1; i <= v.dly; i++) begin
      @(posedge clk); #1;
      if (i == v.dly) set_rsp_ready(v.req, 1'b1);
      @(negedge clk);
      check("rsp_hold_valid", 32'(get_rsp_valid(v.req)), 32'd1);
      check("rsp_hold_rdata", get_rsp_rdata(v.req), v.exp);
    end
    @(negedge clk);
    check("rsp_done", 32'(get_rsp_valid(v.req)), 32'd0);
    $display("txn req%0d we=%0b addr=%h wdata=%h exp_rdata=%h dly=%0d",
             v.req, v.we, v.addr, v.wdata, v.exp, v.dly);
  endtask

  initial begin
    int ng;
    int last_c;
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 256; i++) tb_mem[i] = 32'd0;

    vecs[0] = '{0, 1'b1, 32'h010, 32'hDEADBEEF, 32'h0,        0};
    vecs[1] = '{0, 1'b0, 32'h010, 32'h0,        32'hDEADBEEF, 0};
    vecs[2] = '{1, 1'b1, 32'h024, 32'h12345678, 32'h0,        0};
    vecs[3] = '{1, 1'b0, 32'h024, 32'h0,        32'h12345678, 1};
    vecs[4] = '{0, 1'b0, 32'h025, 32'h0,        32'h12345678, 0};
    vecs[5] = '{0, 1'b1, 32'h010, 32'h00000001, 32'h0,        0};
    vecs[6] = '{1, 1'b1, 32'h3FC, 32'hA5A5A5A5, 32'h0,        2};
    vecs[7] = '{0, 1'b0, 32'h3FC, 32'h0,        32'hA5A5A5A5, 0};
    vecs[8] = '{0, 1'b1, 32'h000, 32'hCAFEF00D, 32'h0,        0};
    vecs[9] = '{1, 1'b0, 32'h400, 32'h0,        32'hCAFEF00D, 0};

    // Reset with both requesters already valid.
    rst_n = 1'b0;
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    drive_req(0, 1'b1, 1'b0, 32'h40, 32'h0);
    drive_req(1, 1'b1, 1'b0, 32'h44, 32'h0);
    @(negedge clk);
    check("rst_req0_ready", 32'(bus.req0_ready), 32'd0);
    check("rst_req1_ready", 32'(bus.req1_ready), 32'd0);
    check("rst_rsp_valid", 32'({bus.rsp0_valid, bus.rsp1_valid}), 32'd0);
    check("rst_mem_rw", 32'({bus.mem_read, bus.mem_write}), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    check("rst_rsp0_rdata", bus.rsp0_rdata, 32'd0);
    check("rst_rsp1_rdata", bus.rsp1_rdata, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Contention: grants alternate 0,1,0,1, one every 3 cycles.
    ng = 0;
    last_c = 0;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      @(negedge clk);
      if (bus.req0_ready || bus.req1_ready) begin
        check("grant_order", 32'(bus.req1_ready), 32'(ng % 2));
        if (ng == 0) check("first_grant_cycle", 32'(c), 32'd0);
        else         check("grant_spacing", 32'(c - last_c), 32'd3);
        last_c = c;
        ng++;
      end
    end
    check("contention_grants", 32'(ng), 32'd4);
    $display("txn contention grants=%0d", ng);
    @(posedge clk); #1;
    drive_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Backpressure on rsp1 while req0 waits.
    bus.rsp1_ready = 1'b0;
    @(posedge clk); #1;
    drive_req(1, 1'b1, 1'b0, 32'h024, 32'h0);
    @(negedge clk);
    check("bp_req1_ready", 32'(bus.req1_ready), 32'd1);
    @(posedge clk); #1;
    drive_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    drive_req(0, 1'b1, 1'b0, 32'h3FC, 32'h0);
    @(negedge clk);
    check("bp_req0_wait_access", 32'(bus.req0_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_rsp1_valid", 32'(bus.rsp1_valid), 32'd1);
      check("bp_rsp1_rdata", bus.rsp1_rdata, 32'h12345678);
      check("bp_req0_wait", 32'(bus.req0_ready), 32'd0);
    end
    @(posedge clk); #1;
    bus.rsp1_ready = 1'b1;
    @(negedge clk);
    check("bp_hs_valid", 32'(bus.rsp1_valid), 32'd1);
    check("bp_hs_req0_wait", 32'(bus.req0_ready), 32'd0);
    @(negedge clk);
    check("bp_rsp1_done", 32'(bus.rsp1_valid), 32'd0);
    check("bp_req0_granted", 32'(bus.req0_ready), 32'd1);
    @(posedge clk); #1;
    drive_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    check("bp_rsp0_valid", 32'(bus.rsp0_valid), 32'd1);
    check("bp_rsp0_rdata", bus.rsp0_rdata, 32'hA5A5A5A5);
    @(negedge clk);
    $display("txn backpressure rsp1 held 5 cycles");

    // Reset during the ACCESS cycle of a read.
    @(posedge clk); #1;
    drive_req(0, 1'b1, 1'b0, 32'h024, 32'h0);
    @(negedge clk);
    check("ra_accept", 32'(bus.req0_ready), 32'd1);
    @(posedge clk); #1;
    drive_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check("ra_in_access", 32'(bus.mem_read), 32'd1);
    rst_n = 1'b0;
    #1;
    check("ra_mem_read", 32'(bus.mem_read), 32'd0);
    check("ra_mem_addr", bus.mem_addr, 32'd0);
    check("ra_mem_wdata", bus.mem_wdata, 32'd0);
    check("ra_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
    check("ra_rsp0_rdata", bus.rsp0_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("ra_no_rsp", 32'(bus.rsp0_valid), 32'd0);
    end
    $display("txn reset during access abandoned");
    run_vec(vecs[4]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
